// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store AXI front end.
//   - request size encodings
//   - controller state enum
//   - AXI response constants
//   - misalignment rule shared by the aligner
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_ILL  = 2'd3;

   localparam logic [1:0] AXI_OKAY    = 2'b00;
   // SLVERR and DECERR both have bit 1 set; that bit alone flags a bus error.
   localparam int         AXI_ERR_BIT = 1;

   typedef enum logic [2:0] {
      IDLE,
      AR,
      R,
      AWW,
      B,
      RESP
   } state_t;

   // Halves need an even address, words a 4-byte aligned one; size 3 is never legal.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = lo[0];
         SZ_WORD: mis = |lo;
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational byte-lane logic.
//   Store side (driven from the live request):
//     st_size, st_addr_lo, st_wdata -> st_lanes (replicated data), st_strb, misalign
//   Load side (driven from the latched request):
//     ld_size, ld_addr_lo, ld_signed, rdata -> ld_data (right-aligned, extended)
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_addr_lo,
   input  logic [31:0] st_wdata,
   output logic [31:0] st_lanes,
   output logic [3:0]  st_strb,
   output logic        misalign,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_addr_lo,
   input  logic        ld_signed,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data
);

   logic [31:0] ld_shift;

   // Data is replicated into every lane so the strobe alone selects the target bytes.
   always_comb begin
      st_lanes = st_wdata;
      st_strb  = 4'hF;
      case (st_size)
         SZ_BYTE: begin
            st_lanes = {4{st_wdata[7:0]}};
            st_strb  = 4'b0001 << st_addr_lo;
         end
         SZ_HALF: begin
            st_lanes = {2{st_wdata[15:0]}};
            st_strb  = 4'b0011 << st_addr_lo;
         end
         default: ;
      endcase
   end

   assign misalign = is_misaligned(st_size, st_addr_lo);

   assign ld_shift = rdata >> {ld_addr_lo, 3'b000};

   always_comb begin
      ld_data = ld_shift;
      case (ld_size)
         SZ_BYTE: ld_data = {{24{ld_signed & ld_shift[7]}}, ld_shift[7:0]};
         SZ_HALF: ld_data = {{16{ld_signed & ld_shift[15]}}, ld_shift[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_axi_master.sv
// lsu_axi_master: single-outstanding CPU load/store to 32-bit AXI4-Lite master.
//   CPU side : req_valid/req_ready handshake with we, addr, size, signed, wdata;
//              resp_valid one-cycle pulse with resp_rdata / resp_err.
//   AXI side : AR/R channels for loads, AW/W/B channels for stores, word-aligned
//              addresses, replicated write data with byte strobes.
//   Misaligned or illegal-size requests complete with an error and no bus traffic.
module lsu_axi_master
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] m_axi_araddr,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   output logic [31:0] m_axi_awaddr,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready
);

   state_t      state;
   logic        accept;
   logic [1:0]  size_q;
   logic [1:0]  lo_q;
   logic        sgn_q;
   logic [31:0] st_lanes;
   logic [3:0]  st_strb;
   logic        misalign;
   logic [31:0] ld_data;
   logic        unused_resp;

   assign accept      = (state == IDLE) && req_valid && req_ready;
   assign unused_resp = ^{m_axi_rresp[0], m_axi_bresp[0]};

   lsu_align u_align (
      .st_size    (req_size),
      .st_addr_lo (req_addr[1:0]),
      .st_wdata   (req_wdata),
      .st_lanes   (st_lanes),
      .st_strb    (st_strb),
      .misalign   (misalign),
      .ld_size    (size_q),
      .ld_addr_lo (lo_q),
      .ld_signed  (sgn_q),
      .rdata      (m_axi_rdata),
      .ld_data    (ld_data)
   );

   // Load-extraction controls only matter after accept, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         size_q <= req_size;
         lo_q   <= req_addr[1:0];
         sgn_q  <= req_signed;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         req_ready     <= 1'b0;
         resp_valid    <= 1'b0;
         resp_rdata    <= 32'h0;
         resp_err      <= 1'b0;
         m_axi_araddr  <= 32'h0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         m_axi_awaddr  <= 32'h0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= 32'h0;
         m_axi_wstrb   <= 4'h0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               req_ready <= !accept;
               if (accept) begin
                  if (misalign) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0;
                     state      <= RESP;
                  end else if (req_we) begin
                     m_axi_awaddr  <= {req_addr[31:2], 2'b00};
                     m_axi_wdata   <= st_lanes;
                     m_axi_wstrb   <= st_strb;
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                     state         <= AWW;
                  end else begin
                     m_axi_araddr  <= {req_addr[31:2], 2'b00};
                     m_axi_arvalid <= 1'b1;
                     state         <= AR;
                  end
               end
            end
            AR: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
                  state         <= R;
               end
            end
            R: begin
               if (m_axi_rvalid) begin
                  m_axi_rready <= 1'b0;
                  resp_valid   <= 1'b1;
                  resp_err     <= m_axi_rresp[AXI_ERR_BIT];
                  resp_rdata   <= m_axi_rresp[AXI_ERR_BIT] ? 32'h0 : ld_data;
                  state        <= RESP;
               end
            end
            AWW: begin
               // AW and W complete independently; a channel already done counts as done.
               if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
               if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
               if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                  m_axi_bready <= 1'b1;
                  state        <= B;
               end
            end
            B: begin
               if (m_axi_bvalid) begin
                  m_axi_bready <= 1'b0;
                  resp_valid   <= 1'b1;
                  resp_err     <= m_axi_bresp[AXI_ERR_BIT];
                  resp_rdata   <= 32'h0;
                  state        <= RESP;
               end
            end
            RESP: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
